// File: rtl/rv32_pkg_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_pkg_lsu
//  Purpose  : Shared types and constants for the RV32 load/store controller
//             (funct3 width codes, FSM state encoding, fault causes).
//  Revision : 1.0  initial release
// ============================================================================
package rv32_pkg_lsu;

   // funct3 width/sign codes as produced by the decoder (ram_req[2:0])
   localparam logic [2:0] LSU_F_B  = 3'b000;
   localparam logic [2:0] LSU_F_H  = 3'b001;
   localparam logic [2:0] LSU_F_W  = 3'b010;
   localparam logic [2:0] LSU_F_BU = 3'b100;
   localparam logic [2:0] LSU_F_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

   typedef logic [1:0] lsu_cause_t;

   localparam lsu_cause_t CAUSE_MISALIGN = 2'd0;
   localparam lsu_cause_t CAUSE_ILLEGAL  = 2'd1;
   localparam lsu_cause_t CAUSE_BUSERR   = 2'd2;
   localparam lsu_cause_t CAUSE_TIMEOUT  = 2'd3;

endpackage : rv32_pkg_lsu
`default_nettype wire

// File: rtl/rv32_mod_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_mod_lsu_align
//  Purpose  : Combinational width decoder shared by the store and load paths:
//             byte enables, lane-replicated store data, extended load data,
//             plus misaligned / illegal-func flags.
//  Revision : 1.0  initial release
// ============================================================================
module rv32_mod_lsu_align
   import rv32_pkg_lsu::*;
(
   input  logic        wr_i,
   input  logic [2:0]  func_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o,
   output logic        illegal_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Decode width code into lanes, replicated store data and extended load data
   always_comb begin
      be_o       = 4'b0000;
      wdata_o    = '0;
      rdata_o    = '0;
      misalign_o = 1'b0;
      illegal_o  = 1'b0;
      byte_sel   = 8'(rdata_i >> {off_i, 3'b000});
      half_sel   = 16'(rdata_i >> {off_i[1], 4'b0000});

      case (func_i)
         LSU_F_B: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{byte_sel[7]}}, byte_sel};
         end
         LSU_F_H: begin
            be_o       = 4'b0011 << off_i;
            misalign_o = off_i[0];
            wdata_o    = {2{wdata_i[15:0]}};
            rdata_o    = {{16{half_sel[15]}}, half_sel};
         end
         LSU_F_W: begin
            be_o       = 4'b1111;
            misalign_o = |off_i;
            wdata_o    = wdata_i;
            rdata_o    = rdata_i;
         end
         LSU_F_BU: begin
            // unsigned widths exist only for loads
            illegal_o = wr_i;
            be_o      = 4'b0001 << off_i;
            rdata_o   = {24'd0, byte_sel};
         end
         LSU_F_HU: begin
            illegal_o  = wr_i;
            misalign_o = off_i[0];
            be_o       = 4'b0011 << off_i;
            rdata_o    = {16'd0, half_sel};
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule : rv32_mod_lsu_align
`default_nettype wire

// File: rtl/rv32_mod_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_mod_lsu_ctrl
//  Purpose  : Load/store sequencer between execute stage and data bus. One
//             access per request: legality/alignment check, single req/ack
//             bus transaction, extended load data or fault cause response.
//  Options  : RV32_LSU_TIMEOUT_EN - abort unacknowledged bus requests after
//             TIMEOUT_CYCLES cycles with fault cause 3.
//  Revision : 1.0  initial release
// ============================================================================
module rv32_mod_lsu_ctrl
   import rv32_pkg_lsu::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [2:0]  req_func,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic [1:0]  rsp_cause,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic        mem_err,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  state_q, state_d;
   logic        wr_q, wr_d;
   logic [2:0]  func_q, func_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;
   lsu_cause_t  cause_q, cause_d;

   logic        al_wr;
   logic [2:0]  al_func;
   logic [1:0]  al_off;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic        al_misalign;
   logic        al_illegal;
   logic        tmo_hit;

   // In IDLE the aligner decodes the incoming request; afterwards it decodes
   // the latched access so the same logic extracts load data from the bus.
   always_comb begin
      al_wr   = (state_q == IDLE) ? req_wr         : wr_q;
      al_func = (state_q == IDLE) ? req_func       : func_q;
      al_off  = (state_q == IDLE) ? req_addr[1:0]  : off_q;
   end

   rv32_mod_lsu_align u_align (
      .wr_i       (al_wr),
      .func_i     (al_func),
      .off_i      (al_off),
      .wdata_i    (req_wdata),
      .rdata_i    (mem_rdata),
      .be_o       (al_be),
      .wdata_o    (al_wdata),
      .rdata_o    (al_rdata),
      .misalign_o (al_misalign),
      .illegal_o  (al_illegal)
   );

`ifdef RV32_LSU_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count BUS cycles; the count restarts from zero on each entry to BUS
   always_comb begin
      cnt_d = (state_q == BUS) ? cnt_q + 1'b1 : '0;
   end

   // Timeout counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Last permitted BUS cycle without completion
   always_comb begin
      tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   end
`else
   logic unused_tmo;

   // Without the timeout option the bus wait is unbounded
   always_comb begin
      tmo_hit    = 1'b0;
      unused_tmo = (TIMEOUT_CYCLES != 0);
   end
`endif

   // Next-state and latched access/response data
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      func_d  = func_q;
      off_d   = off_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      cause_d = cause_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wr_d    = req_wr;
               func_d  = req_func;
               off_d   = req_addr[1:0];
               addr_d  = {req_addr[31:2], 2'b00};
               // lanes and data only drive the bus for writes
               be_d    = req_wr ? al_be    : 4'b0000;
               wdata_d = req_wr ? al_wdata : '0;
               rdata_d = '0;
               fault_d = 1'b0;
               cause_d = CAUSE_MISALIGN;
               if (al_illegal) begin
                  fault_d = 1'b1;
                  cause_d = CAUSE_ILLEGAL;
                  state_d = RESP;
               end else if (al_misalign) begin
                  fault_d = 1'b1;
                  cause_d = CAUSE_MISALIGN;
                  state_d = RESP;
               end else begin
                  state_d = BUS;
               end
            end
         end
         BUS: begin
            if (mem_err) begin
               fault_d = 1'b1;
               cause_d = CAUSE_BUSERR;
               rdata_d = '0;
               state_d = RESP;
            end else if (mem_ack) begin
               fault_d = 1'b0;
               rdata_d = wr_q ? '0 : al_rdata;
               state_d = RESP;
            end else if (tmo_hit) begin
               fault_d = 1'b1;
               cause_d = CAUSE_TIMEOUT;
               rdata_d = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         func_q  <= '0;
         off_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
         cause_q <= CAUSE_MISALIGN;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         func_q  <= func_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
      end
   end

   // Outputs decoded from the registered state; all zero outside their state
   always_comb begin
      req_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
      mem_req   = (state_q == BUS);
      mem_wr    = mem_req & wr_q;
      mem_addr  = mem_req ? addr_q  : '0;
      mem_be    = mem_req ? be_q    : 4'b0000;
      mem_wdata = mem_req ? wdata_q : '0;
      rsp_valid = (state_q == RESP);
      rsp_rdata = rsp_valid ? rdata_q : '0;
      rsp_fault = rsp_valid & fault_q;
      rsp_cause = rsp_valid ? cause_q : CAUSE_MISALIGN;
   end

endmodule : rv32_mod_lsu_ctrl
`default_nettype wire

// File: tb/tb_rv32_mod_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32_mod_lsu_ctrl
//  Purpose  : Directed, table-driven bench for the RV32 load/store controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv32_mod_lsu_ctrl;

`ifdef RV32_LSU_TIMEOUT_EN
   localparam int unsigned TMO = 4;
`else
   localparam int unsigned TMO = 255;
`endif

   logic        clk, rst;
   logic        req_valid, req_ready, req_wr;
   logic [2:0]  req_func;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_fault, busy;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_cause;
   logic        mem_req, mem_wr, mem_ack, mem_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int n_vec = 0;
   int n_mis = 0;

   rv32_mod_lsu_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_func  (req_func),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_fault (rsp_fault),
      .rsp_cause (rsp_cause),
      .busy      (busy),
      .mem_req   (mem_req),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_err   (mem_err),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [2:0]  func;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          k;          // cycle at which the bus completes
      logic        ack;
      logic        err;
      logic        exp_bus;
      logic        exp_fault;
      logic [1:0]  exp_cause;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at a falling edge with the DUT in IDLE
   task automatic run_vec(input vec_t v, input int idx);
      chk($sformatf("v%0d ready_idle", idx), 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_wr    = v.wr;
      req_func  = v.func;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      @(negedge clk);
      req_valid = 1'b0;
      if (v.exp_bus) begin
         chk($sformatf("v%0d mem_req", idx), 32'(mem_req), 32'd1);
         chk($sformatf("v%0d mem_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
         chk($sformatf("v%0d mem_wr", idx), 32'(mem_wr), 32'(v.wr));
         chk($sformatf("v%0d mem_be", idx), 32'(mem_be), 32'(v.exp_be));
         if (v.wr) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
         chk($sformatf("v%0d rdata_quiet", idx), rsp_rdata, 32'd0);
         for (int c = 1; c < v.k; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d mem_req_hold", idx), 32'(mem_req), 32'd1);
            chk($sformatf("v%0d rsp_early", idx), 32'(rsp_valid), 32'd0);
         end
         mem_ack   = v.ack;
         mem_err   = v.err;
         mem_rdata = v.rdata;
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_err   = 1'b0;
         mem_rdata = $urandom;
      end else begin
         chk($sformatf("v%0d no_mem_req", idx), 32'(mem_req), 32'd0);
      end
      chk($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d rsp_fault", idx), 32'(rsp_fault), 32'(v.exp_fault));
      if (v.exp_fault) chk($sformatf("v%0d rsp_cause", idx), 32'(rsp_cause), 32'(v.exp_cause));
      chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d mem_req_off", idx), 32'(mem_req), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d rsp_one_shot", idx), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d rdata_zero", idx), rsp_rdata, 32'd0);
      chk($sformatf("v%0d ready_back", idx), 32'(req_ready), 32'd1);
   endtask

   initial begin
      int n;
      //        wr    func    addr          wdata         rdata        k  ack   err   bus   flt   cause exp_rdata     be       exp_wdata
      tbl[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_FF7F, 3, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'hFFFF_FF80, 4'b0000, 32'h0};
      tbl[1]  = '{1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,       1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        4'b1100, 32'hABCD_ABCD};
      tbl[2]  = '{1'b0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,        0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        4'b0000, 32'h0};
      tbl[3]  = '{1'b0, 3'b011, 32'h0000_3000, 32'h0,        32'h0,        0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0,        4'b0000, 32'h0};
      tbl[4]  = '{1'b0, 3'b101, 32'h0000_4002, 32'h0,        32'h1234_5678, 2, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 32'h0,        4'b0000, 32'h0};
      tbl[5]  = '{1'b0, 3'b101, 32'h0000_4002, 32'h0,        32'h8765_1234, 1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_8765, 4'b0000, 32'h0};
      tbl[6]  = '{1'b0, 3'b001, 32'h0000_4002, 32'h0,        32'h8765_1234, 2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'hFFFF_8765, 4'b0000, 32'h0};
      tbl[7]  = '{1'b0, 3'b100, 32'h0000_5001, 32'h0,        32'h1122_8344, 1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0083, 4'b0000, 32'h0};
      tbl[8]  = '{1'b1, 3'b000, 32'h0000_6001, 32'hAABB_CC5A, 32'h0,       1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        4'b0010, 32'h5A5A_5A5A};
      tbl[9]  = '{1'b1, 3'b010, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0,       2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        4'b1111, 32'hDEAD_BEEF};
      tbl[10] = '{1'b0, 3'b010, 32'h0000_8000, 32'h0,        32'hCAFE_F00D, 1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'hCAFE_F00D, 4'b0000, 32'h0};
      tbl[11] = '{1'b1, 3'b101, 32'h0000_9001, 32'h0,        32'h0,        0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0,        4'b0000, 32'h0};
      tbl[12] = '{1'b0, 3'b110, 32'h0000_A003, 32'h0,        32'h0,        0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0,        4'b0000, 32'h0};
      tbl[13] = '{1'b1, 3'b001, 32'h0000_B001, 32'h0,        32'h0,        0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        4'b0000, 32'h0};
      tbl[14] = '{1'b0, 3'b000, 32'h0000_C000, 32'h0,        32'h0000_00FF, 2, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 32'h0,        4'b0000, 32'h0};
      tbl[15] = '{1'b0, 3'b000, 32'h0000_C002, 32'h0,        32'h00A5_0000, 1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'hFFFF_FFA5, 4'b0000, 32'h0};
      tbl[16] = '{1'b0, 3'b001, 32'h0000_C000, 32'h0,        32'h0000_7FFF, 1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_7FFF, 4'b0000, 32'h0};

      rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_func = '0;
      req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst req_ready", 32'(req_ready), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst mem_be", 32'(mem_be), 32'd0);
      chk("rst mem_addr", mem_addr, 32'd0);
      chk("rst rsp_rdata", rsp_rdata, 32'd0);

      for (int i = 0; i < 17; i++) run_vec(tbl[i], i);

      // completion strobes outside BUS are ignored
      mem_ack = 1'b1; mem_err = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; mem_err = 1'b0;
      chk("idle_ack busy", 32'(busy), 32'd0);
      chk("idle_ack rsp_valid", 32'(rsp_valid), 32'd0);

      // asynchronous reset in the middle of a bus transaction
      req_valid = 1'b1; req_wr = 1'b0; req_func = 3'b010; req_addr = 32'h0000_D000;
      @(negedge clk);
      req_valid = 1'b0;
      chk("arst pre mem_req", 32'(mem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst mem_req", 32'(mem_req), 32'd0);
      chk("arst req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("arst no_rsp", 32'(rsp_valid), 32'd0);
         chk("arst ready", 32'(req_ready), 32'd1);
      end

      // back-to-back: request held through RESP is taken in the next IDLE cycle
      req_valid = 1'b1; req_wr = 1'b1; req_func = 3'b010; req_addr = 32'h0000_0100; req_wdata = 32'h1;
      @(negedge clk);
      chk("b2b busy_ready", 32'(req_ready), 32'd0);
      mem_ack = 1'b1;
      req_wr = 1'b0; req_addr = 32'h0000_0204;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("b2b rsp_valid", 32'(rsp_valid), 32'd1);
      chk("b2b resp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("b2b idle_ready", 32'(req_ready), 32'd1);
      chk("b2b not_taken_in_resp", 32'(mem_req), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b second mem_req", 32'(mem_req), 32'd1);
      chk("b2b second mem_addr", mem_addr, 32'h0000_0204);
      chk("b2b second mem_wr", 32'(mem_wr), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("b2b second rdata", rsp_rdata, 32'h0000_0055);
      @(negedge clk);

`ifdef RV32_LSU_TIMEOUT_EN
      // no completion: request held for TIMEOUT cycles, then cause 3
      req_valid = 1'b1; req_wr = 1'b0; req_func = 3'b010; req_addr = 32'h0000_E000;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (mem_req && n < 10) begin
         n++;
         @(negedge clk);
      end
      chk("tmo req_cycles", 32'(n), 32'd4);
      chk("tmo rsp_valid", 32'(rsp_valid), 32'd1);
      chk("tmo fault", 32'(rsp_fault), 32'd1);
      chk("tmo cause", 32'(rsp_cause), 32'd3);
      chk("tmo rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      // completion on the last permitted cycle wins over the timeout
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("tmo_edge rsp_valid", 32'(rsp_valid), 32'd1);
      chk("tmo_edge fault", 32'(rsp_fault), 32'd0);
      chk("tmo_edge rdata", rsp_rdata, 32'h0BAD_F00D);
      @(negedge clk);
`else
      // without the timeout option the bus waits indefinitely
      req_valid = 1'b1; req_wr = 1'b0; req_func = 3'b010; req_addr = 32'h0000_E000;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         if (rsp_valid) n++;
         @(negedge clk);
      end
      chk("nowait mem_req", 32'(mem_req), 32'd1);
      chk("nowait no_rsp", 32'(n), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("nowait fault", 32'(rsp_fault), 32'd0);
      chk("nowait rdata", rsp_rdata, 32'h0BAD_F00D);
      @(negedge clk);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule : tb_rv32_mod_lsu_ctrl
`default_nettype wire
